// File: rtl/exotiny_bus_if.sv
// Signal bundle between the two FazyRV masters, the interconnect and its slaves.
// "slave" is the interconnect's view; "master" is the view of the surrounding cores and peripherals.
interface exotiny_bus_if #(
  parameter int NSLV = 2
);
  logic              im_stb_i;
  logic [31:0]       im_adr_i;
  logic [31:0]       im_dat_o;
  logic              im_ack_o;
  logic              im_err_o;

  logic              dm_stb_i;
  logic              dm_we_i;
  logic [3:0]        dm_be_i;
  logic [31:0]       dm_adr_i;
  logic [31:0]       dm_dat_i;
  logic [31:0]       dm_dat_o;
  logic              dm_ack_o;
  logic              dm_err_o;

  logic [NSLV-1:0]    s_stb_o;
  logic               s_we_o;
  logic [3:0]         s_be_o;
  logic [31:0]        s_adr_o;
  logic [31:0]        s_dat_o;
  logic [NSLV*32-1:0] s_dat_i;
  logic [NSLV-1:0]    s_ack_i;

  modport slave (
    input  im_stb_i, im_adr_i,
    output im_dat_o, im_ack_o, im_err_o,
    input  dm_stb_i, dm_we_i, dm_be_i, dm_adr_i, dm_dat_i,
    output dm_dat_o, dm_ack_o, dm_err_o,
    output s_stb_o, s_we_o, s_be_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output im_stb_i, im_adr_i,
    input  im_dat_o, im_ack_o, im_err_o,
    output dm_stb_i, dm_we_i, dm_be_i, dm_adr_i, dm_dat_i,
    input  dm_dat_o, dm_ack_o, dm_err_o,
    input  s_stb_o, s_we_o, s_be_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/exotiny_bus.sv
// Wishbone interconnect: round-robin arbitration of instruction/data masters,
// base/mask slave decode, decode-error and timeout bus-error responses.
module exotiny_bus #(
  parameter int                 NSLV     = 2,
  parameter logic [NSLV*32-1:0] SLV_BASE = {32'h1000_0000, 32'h0000_0000},
  parameter logic [NSLV*32-1:0] SLV_MASK = {32'hF000_0000, 32'hF000_0000},
  parameter int                 TOUTW    = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  exotiny_bus_if.slave bus
);
  localparam int SELW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [TOUTW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_gnt_d;
  logic              r_last_d;
  logic [SELW-1:0]   r_sel;
  logic              r_hit;
  logic [TOUTW-1:0]  r_cnt;
  logic [TOUTW-1:0]  w_cnt_next;

  logic              w_pick_d;
  logic [31:0]       w_req_adr;
  logic [NSLV-1:0]   w_match;
  logic              w_hit;
  logic [SELW-1:0]   w_dec_sel;
  logic [31:0]       w_slv_dat [NSLV];
  logic              w_gnt_stb;
  logic              w_grant;
  logic              w_stb;
  logic              w_ack;
  logic              w_err;

  // On contention the master that was not granted last wins.
  assign w_pick_d  = bus.dm_stb_i & (~bus.im_stb_i | ~r_last_d);
  assign w_req_adr = w_pick_d ? bus.dm_adr_i : bus.im_adr_i;
  assign w_hit     = |w_match;
  assign w_gnt_stb = r_gnt_d ? bus.dm_stb_i : bus.im_stb_i;

  for (genvar gi = 0; gi < NSLV; gi++) begin : g_slv
    assign w_match[gi]     = (w_req_adr & SLV_MASK[gi*32 +: 32]) == SLV_BASE[gi*32 +: 32];
    assign w_slv_dat[gi]   = bus.s_dat_i[gi*32 +: 32];
    assign bus.s_stb_o[gi] = w_stb && (r_sel == SELW'(gi));
  end

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    w_dec_sel = '0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (w_match[k]) w_dec_sel = SELW'(k);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_grant      = 1'b0;
    w_stb        = 1'b0;
    w_ack        = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.im_stb_i || bus.dm_stb_i) begin
          w_grant      = 1'b1;
          w_cnt_next   = '0;
          w_state_next = w_hit ? S_BUSY : S_ERR;
        end
      end
      S_BUSY: begin
        if (!w_gnt_stb) begin
          w_state_next = S_IDLE;
        end else begin
          w_stb = 1'b1;
          if (bus.s_ack_i[r_sel]) begin
            w_ack        = 1'b1;
            w_state_next = S_IDLE;
          end else if (r_cnt == CNT_MAX - 1'b1) begin
            w_cnt_next   = CNT_MAX;
            w_state_next = S_ERR;
          end else if (r_cnt != CNT_MAX) begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      S_ERR: begin
        w_err        = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_gnt_d  <= 1'b0;
      r_last_d <= 1'b1;
      r_sel    <= '0;
      r_hit    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_grant) begin
        r_gnt_d  <= w_pick_d;
        r_last_d <= w_pick_d;
        r_sel    <= w_dec_sel;
        r_hit    <= w_hit;
      end
    end
  end

  assign bus.s_we_o  = r_gnt_d & bus.dm_we_i;
  assign bus.s_be_o  = r_gnt_d ? bus.dm_be_i : 4'hF;
  assign bus.s_adr_o = r_gnt_d ? bus.dm_adr_i : bus.im_adr_i;
  assign bus.s_dat_o = bus.dm_dat_i;

  assign bus.im_ack_o = w_ack & ~r_gnt_d;
  assign bus.dm_ack_o = w_ack &  r_gnt_d;
  assign bus.im_err_o = w_err & ~r_gnt_d;
  assign bus.dm_err_o = w_err &  r_gnt_d;
  assign bus.im_dat_o = r_hit ? w_slv_dat[r_sel] : 32'h0;
  assign bus.dm_dat_o = r_hit ? w_slv_dat[r_sel] : 32'h0;
endmodule

// File: tb/tb_exotiny_bus.sv
// Directed bench for exotiny_bus: a per-cycle vector table for the basic transactions
// plus hand-written sequences for timeout, abort and asynchronous reset.
module tb_exotiny_bus;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exotiny_bus_if #(.NSLV(2)) bus();

  exotiny_bus #(
    .NSLV    (2),
    .SLV_BASE({32'h1000_0000, 32'h0000_0000}),
    .SLV_MASK({32'hF000_0000, 32'hF000_0000}),
    .TOUTW   (4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  localparam logic [31:0] DAT0 = 32'hDEAD_BEEF;
  localparam logic [31:0] DAT1 = 32'h0000_1234;
  localparam logic [31:0] WDAT = 32'hA5A5_5A5A;
  localparam logic [31:0] IA   = 32'h0000_0100;
  localparam logic [31:0] DA   = 32'h1000_0004;
  localparam logic [31:0] EA   = 32'h2000_0000;
  localparam logic [31:0] RI   = 32'h0000_0200;
  localparam logic [31:0] RD   = 32'h1000_0008;

  // e_st = {s_stb[1:0], im_ack, dm_ack, im_err, dm_err}
  typedef struct {
    logic        istb;
    logic [31:0] iadr;
    logic        dstb;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] dadr;
    logic [1:0]  ack;
    logic [5:0]  e_st;
    logic        gd;
    logic [31:0] e_dat;
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic istb, input logic [31:0] iadr, input logic dstb,
                              input logic dwe, input logic [3:0] dbe, input logic [31:0] dadr,
                              input logic [1:0] ack, input logic [5:0] e_st, input logic gd,
                              input logic [31:0] e_dat);
    vec_t v;
    v.istb = istb; v.iadr = iadr; v.dstb = dstb; v.dwe = dwe; v.dbe = dbe;
    v.dadr = dadr; v.ack = ack; v.e_st = e_st; v.gd = gd; v.e_dat = e_dat;
    return v;
  endfunction

  function automatic logic [5:0] st();
    return {bus.s_stb_o, bus.im_ack_o, bus.dm_ack_o, bus.im_err_o, bus.dm_err_o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic istb, input logic [31:0] iadr, input logic dstb,
                       input logic dwe, input logic [3:0] dbe, input logic [31:0] dadr,
                       input logic [1:0] ack);
    bus.im_stb_i = istb;
    bus.im_adr_i = iadr;
    bus.dm_stb_i = dstb;
    bus.dm_we_i  = dwe;
    bus.dm_be_i  = dbe;
    bus.dm_adr_i = dadr;
    bus.s_ack_i  = ack;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 2'b00);
  endtask

  // Check status at the falling edge, then move to 1 ns after the next rising edge.
  task automatic cyc(input string nm, input logic [5:0] e);
    @(negedge clk);
    chk(nm, {26'd0, st()}, {26'd0, e});
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.dm_dat_i = WDAT;
    bus.s_dat_i  = {DAT1, DAT0};
    rst = 1'b1;
    drive(1'b1, IA, 1'b1, 1'b1, 4'hF, DA, 2'b11);
    @(negedge clk);
    chk("reset_outputs", {26'd0, st()}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    @(posedge clk);
    #1;

    // Data write, zero-wait slave 1.
    tbl.push_back(mk(0, 0, 1, 1, 4'h3, DA, 2'b00, 6'b00_0000, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 4'h3, DA, 2'b10, 6'b10_0100, 1, DAT1));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0,  2'b00, 6'b00_0000, 0, 0));
    // Instruction fetch, slave 0 acks after 5 wait states; a stray slave-1 ack is ignored.
    tbl.push_back(mk(1, IA, 0, 0, 4'h0, 0, 2'b00, 6'b00_0000, 0, 0));
    tbl.push_back(mk(1, IA, 0, 0, 4'h0, 0, 2'b00, 6'b01_0000, 0, 0));
    tbl.push_back(mk(1, IA, 0, 0, 4'h0, 0, 2'b10, 6'b01_0000, 0, 0));
    tbl.push_back(mk(1, IA, 0, 0, 4'h0, 0, 2'b00, 6'b01_0000, 0, 0));
    tbl.push_back(mk(1, IA, 0, 0, 4'h0, 0, 2'b00, 6'b01_0000, 0, 0));
    tbl.push_back(mk(1, IA, 0, 0, 4'h0, 0, 2'b00, 6'b01_0000, 0, 0));
    tbl.push_back(mk(1, IA, 0, 0, 4'h0, 0, 2'b01, 6'b01_1000, 0, DAT0));
    tbl.push_back(mk(0, 0,  0, 0, 4'h0, 0, 2'b00, 6'b00_0000, 0, 0));
    // Unmapped data read: err for one cycle, no strobe.
    tbl.push_back(mk(0, 0, 1, 0, 4'hF, EA, 2'b11, 6'b00_0000, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'hF, EA, 2'b11, 6'b00_0001, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0,  2'b00, 6'b00_0000, 0, 0));
    // Continuous contention, both slaves acking: grants alternate I, D.
    for (int t = 0; t < 3; t++) begin
      tbl.push_back(mk(1, RI, 1, 1, 4'hC, RD, 2'b11, 6'b00_0000, 0, 0));
      tbl.push_back(mk(1, RI, 1, 1, 4'hC, RD, 2'b11, 6'b01_1000, 0, DAT0));
      tbl.push_back(mk(1, RI, 1, 1, 4'hC, RD, 2'b11, 6'b00_0000, 0, 0));
      tbl.push_back(mk(1, RI, 1, 1, 4'hC, RD, 2'b11, 6'b10_0100, 1, DAT1));
    end
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0, 2'b00, 6'b00_0000, 0, 0));

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].istb, tbl[r].iadr, tbl[r].dstb, tbl[r].dwe, tbl[r].dbe, tbl[r].dadr, tbl[r].ack);
      @(negedge clk);
      chk($sformatf("row%0d_status", r), {26'd0, st()}, {26'd0, tbl[r].e_st});
      if (tbl[r].e_st[5:4] != 2'b00) begin
        chk($sformatf("row%0d_we", r), {31'd0, bus.s_we_o}, {31'd0, tbl[r].gd & tbl[r].dwe});
        chk($sformatf("row%0d_be", r), {28'd0, bus.s_be_o}, {28'd0, tbl[r].gd ? tbl[r].dbe : 4'hF});
        chk($sformatf("row%0d_adr", r), bus.s_adr_o, tbl[r].gd ? tbl[r].dadr : tbl[r].iadr);
        if (tbl[r].gd) chk($sformatf("row%0d_wdat", r), bus.s_dat_o, WDAT);
      end
      if (tbl[r].e_st[3]) chk($sformatf("row%0d_im_dat", r), bus.im_dat_o, tbl[r].e_dat);
      if (tbl[r].e_st[2]) chk($sformatf("row%0d_dm_dat", r), bus.dm_dat_o, tbl[r].e_dat);
      $display("row %0d: istb=%b dstb=%b ack=%b status=%b", r, tbl[r].istb, tbl[r].dstb,
               tbl[r].ack, st());
      @(posedge clk);
      #1;
    end

    // Silent slave: 15 busy cycles, then a single err pulse.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h1000_0010, 2'b00);
    cyc("to_req", 6'b00_0000);
    for (int i = 1; i <= 15; i++) cyc($sformatf("to_busy%0d", i), 6'b10_0000);
    cyc("to_err", 6'b00_0001);
    idle();
    cyc("to_idle", 6'b00_0000);
    $display("seq timeout: done");

    // Ack in the final busy cycle beats the timeout.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h1000_0010, 2'b00);
    cyc("late_req", 6'b00_0000);
    for (int i = 1; i <= 14; i++) cyc($sformatf("late_busy%0d", i), 6'b10_0000);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h1000_0010, 2'b10);
    cyc("late_ack", 6'b10_0100);
    idle();
    cyc("late_noerr", 6'b00_0000);
    $display("seq late ack: done");

    // Abort in cycle 3 coinciding with a slave ack: no ack, no err.
    drive(1'b1, IA, 1'b0, 1'b0, 4'h0, 32'h0, 2'b00);
    cyc("ab_req", 6'b00_0000);
    cyc("ab_busy1", 6'b01_0000);
    cyc("ab_busy2", 6'b01_0000);
    drive(1'b0, IA, 1'b0, 1'b0, 4'h0, 32'h0, 2'b01);
    cyc("ab_abort", 6'b00_0000);
    idle();
    cyc("ab_after", 6'b00_0000);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'h5, DA, 2'b10);
    cyc("ab_next_req", 6'b00_0000);
    cyc("ab_next_ack", 6'b10_0100);
    idle();
    cyc("ab_next_idle", 6'b00_0000);
    $display("seq abort: done");

    // Reset mid-BUSY on an instruction grant; strobe must drop without a clock edge.
    drive(1'b1, IA, 1'b0, 1'b0, 4'h0, 32'h0, 2'b00);
    cyc("rst_req", 6'b00_0000);
    cyc("rst_busy", 6'b01_0000);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_drop", {26'd0, st()}, 32'd0);
    @(negedge clk);
    chk("rst_held", {26'd0, st()}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // After reset the last-grant pointer is data, so contention grants instruction.
    drive(1'b1, RI, 1'b1, 1'b1, 4'hF, RD, 2'b11);
    cyc("rst_contend", 6'b00_0000);
    @(negedge clk);
    chk("rst_first_grant", {26'd0, st()}, {26'd0, 6'b01_1000});
    chk("rst_first_dat", bus.im_dat_o, DAT0);
    @(posedge clk);
    #1;
    idle();
    cyc("rst_final_idle", 6'b00_0000);
    $display("seq reset: done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
